// File: rtl/cnn_frame_loader.sv
// Frame loader for the simpleCNN core: streams a raster image into the CNN input
// buffer, starts the core, and hands back the classified digit over valid/ready.
module cnn_frame_loader #(
    parameter int IMG_W   = 28,
    parameter int IMG_H   = 28,
    parameter int PIX_W   = 32,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [PIX_W-1:0] s_data,
    input  logic             s_last,
    output logic             wr_en,
    output logic [4:0]       wr_row,
    output logic [4:0]       wr_col,
    output logic [PIX_W-1:0] wr_data,
    output logic             cnn_enable,
    input  logic             cnn_done,
    input  logic [3:0]       cnn_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [3:0]       res_digit,
    output logic             res_err
);

    typedef enum logic [1:0] {
        LOAD,
        RUN,
        RESULT
    } state_t;

    localparam int              WD_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [4:0]      LAST_COL = 5'(IMG_W - 1);
    localparam logic [4:0]      LAST_ROW = 5'(IMG_H - 1);
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [3:0]      ERR_DIGIT = 4'hF;

    state_t          state, state_next;
    logic [4:0]      row, col;
    logic [WD_W-1:0] wdog;
    logic            pix_hs, at_end, frame_end, frame_good, wd_expired;

    assign pix_hs     = s_valid && s_ready;
    assign at_end     = (row == LAST_ROW) && (col == LAST_COL);
    assign frame_end  = pix_hs && (s_last || at_end);
    assign frame_good = s_last && at_end;
    assign wd_expired = (state == RUN) && (wdog == WD_LAST);

    // NOTE: state_next gets its default before the case so no path can infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            LOAD:    if (frame_end) state_next = frame_good ? RUN : RESULT;
            RUN:     if (cnn_done || wd_expired) state_next = RESULT;
            RESULT:  if (res_ready) state_next = LOAD;
            default: state_next = LOAD;
        endcase
    end

    // Handshake outputs are registered decodes of the next state, so they change
    // on the same edge that samples the triggering input.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= LOAD;
            row        <= '0;
            col        <= '0;
            wdog       <= '0;
            s_ready    <= 1'b1;
            wr_en      <= 1'b0;
            wr_row     <= '0;
            wr_col     <= '0;
            wr_data    <= '0;
            cnn_enable <= 1'b0;
            res_valid  <= 1'b0;
            res_digit  <= '0;
            res_err    <= 1'b0;
        end else begin
            state      <= state_next;
            s_ready    <= (state_next == LOAD);
            cnn_enable <= (state_next == RUN);
            res_valid  <= (state_next == RESULT);
            wr_en      <= pix_hs;

            if (pix_hs) begin
                wr_row  <= row;
                wr_col  <= col;
                wr_data <= s_data;
                if (s_last || at_end) begin
                    row <= '0;
                    col <= '0;
                end else if (col == LAST_COL) begin
                    col <= '0;
                    row <= row + 5'd1;
                end else begin
                    col <= col + 5'd1;
                end
            end

            // Dropped frame: either s_last came early or the final pixel lacked it.
            if (frame_end && !frame_good) begin
                res_digit <= ERR_DIGIT;
                res_err   <= 1'b1;
            end

            if (state == RUN) begin
                wdog <= wdog + 1'b1;
                if (cnn_done) begin
                    res_digit <= cnn_result;
                    res_err   <= (cnn_result > 4'd9);
                end else if (wd_expired) begin
                    res_digit <= ERR_DIGIT;
                    res_err   <= 1'b1;
                end
            end else begin
                wdog <= '0;
            end
        end
    end

endmodule

// File: tb/tb_cnn_frame_loader.sv
// Scoreboard bench for cnn_frame_loader: stimulus queues expected writes/results,
// independent monitors pop and compare whenever the DUT presents them.
module tb_cnn_frame_loader;

    localparam int IMG_W = 28;
    localparam int IMG_H = 28;
    localparam int PIX_W = 32;
    localparam int NPIX  = IMG_W * IMG_H;

    typedef struct packed {
        logic [4:0]       row;
        logic [4:0]       col;
        logic [PIX_W-1:0] data;
    } wr_t;

    typedef struct packed {
        logic [3:0] digit;
        logic       err;
    } res_t;

    logic             clk;
    logic             rst;
    logic             s_valid;
    logic             s_ready;
    logic [PIX_W-1:0] s_data;
    logic             s_last;
    logic             wr_en;
    logic [4:0]       wr_row;
    logic [4:0]       wr_col;
    logic [PIX_W-1:0] wr_data;
    logic             cnn_enable;
    logic             cnn_done;
    logic [3:0]       cnn_result;
    logic             res_valid;
    logic             res_ready;
    logic [3:0]       res_digit;
    logic             res_err;

    wr_t  wr_q[$];
    res_t res_q[$];
    int   total = 0;
    int   bad = 0;
    int   en_rises = 0;
    int   exp_rises = 0;

    cnn_frame_loader #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .PIX_W  (PIX_W),
        .TIMEOUT(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .wr_en     (wr_en),
        .wr_row    (wr_row),
        .wr_col    (wr_col),
        .wr_data   (wr_data),
        .cnn_enable(cnn_enable),
        .cnn_done  (cnn_done),
        .cnn_result(cnn_result),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_digit (res_digit),
        .res_err   (res_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Write monitor: every wr_en pulse must match the oldest queued pixel.
    initial begin
        logic prev_en;
        wr_t  exp_w;
        prev_en = 1'b0;
        forever begin
            @(negedge clk);
            if (cnn_enable && !prev_en) en_rises++;
            prev_en = cnn_enable;
            if (wr_en === 1'b1) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_write", {wr_row, wr_col, wr_data}, '1);
                end else begin
                    exp_w = wr_q.pop_front();
                    check("write", {wr_row, wr_col, wr_data}, exp_w);
                end
            end
        end
    end

    // Result monitor: each new res_valid must match the oldest queued result.
    initial begin
        logic prev_v;
        res_t exp_r;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (res_valid === 1'b1 && !prev_v) begin
                if (res_q.size() == 0) begin
                    check("unexpected_result", {res_digit, res_err}, '1);
                end else begin
                    exp_r = res_q.pop_front();
                    check("result", {res_digit, res_err}, exp_r);
                end
            end
            prev_v = (res_valid === 1'b1);
        end
    end

    initial begin
        #2ms;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic check_reset_state(input string name);
        check({name, "_sready"}, s_ready, 1);
        check({name, "_outs"}, {wr_en, cnn_enable, res_valid, res_err, res_digit, wr_row, wr_col}, 0);
        check({name, "_wdata"}, wr_data, 0);
    endtask

    task automatic reset_pulse(input string name);
        rst = 1'b0;
        s_valid = 1'b0;
        s_last = 1'b0;
        cnn_done = 1'b0;
        res_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check_reset_state(name);
    endtask

    // Offers pixels 0..n-1; last_idx < 0 means no s_last at all.
    task automatic send_frame(input int n, input int last_idx, input bit gap);
        wr_t w;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (gap && i[0]) begin
                s_valid = 1'b0;
                s_last = 1'b0;
                @(negedge clk);
            end
            s_valid = 1'b1;
            s_data = PIX_W'(i);
            s_last = (i == last_idx);
            w.row = 5'(i / IMG_W);
            w.col = 5'(i % IMG_W);
            w.data = PIX_W'(i);
            wr_q.push_back(w);
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    // Called at the first negedge with cnn_enable high; done is sampled delay cycles later.
    task automatic run_cnn(input int delay, input logic [3:0] val, input logic [3:0] ed, input logic ee);
        res_t r;
        check("enable_on", cnn_enable, 1);
        for (int i = 1; i < delay; i++) @(negedge clk);
        r.digit = ed;
        r.err = ee;
        res_q.push_back(r);
        cnn_done = 1'b1;
        cnn_result = val;
        @(negedge clk);
        cnn_done = 1'b0;
        cnn_result = 4'd0;
        check("done_to_result", {res_valid, cnn_enable}, 2'b10);
    endtask

    // Holds res_ready low for hold cycles while poking ignored inputs, then accepts.
    task automatic accept(input int hold, input logic [3:0] d, input logic e);
        for (int i = 0; i < hold; i++) begin
            check("result_hold", {res_valid, res_digit, res_err, s_ready}, {1'b1, d, e, 1'b0});
            s_valid = 1'b1;
            s_last = (i == 3);
            s_data = 32'hDEAD;
            cnn_done = 1'b1;
            cnn_result = 4'd5;
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_last = 1'b0;
        cnn_done = 1'b0;
        cnn_result = 4'd0;
        check("result_pending", res_valid, 1);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("accept", {res_valid, s_ready}, 2'b01);
    endtask

    task automatic push_err_result();
        res_t r;
        r.digit = 4'hF;
        r.err = 1'b1;
        res_q.push_back(r);
    endtask

    initial begin
        int cnt;
        rst = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        s_last = 1'b0;
        cnn_done = 1'b0;
        cnn_result = 4'd0;
        res_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        check_reset_state("reset");

        // Good frame, done 5 cycles after enable.
        send_frame(NPIX, NPIX - 1, 1'b0);
        exp_rises++;
        check("enable_with_last_wr", {cnn_enable, wr_en, wr_row, wr_col}, {1'b1, 1'b1, 5'd27, 5'd27});
        run_cnn(5, 4'd7, 4'd7, 1'b0);
        accept(0, 4'd7, 1'b0);

        // Gapped stream, result held under backpressure.
        send_frame(NPIX, NPIX - 1, 1'b1);
        exp_rises++;
        run_cnn(3, 4'd2, 4'd2, 1'b0);
        accept(10, 4'd2, 1'b0);

        // Early s_last on pixel 100, then a normal frame.
        push_err_result();
        send_frame(101, 100, 1'b0);
        check("early_last", {res_valid, cnn_enable}, 2'b10);
        accept(2, 4'hF, 1'b1);
        send_frame(NPIX, NPIX - 1, 1'b0);
        exp_rises++;
        run_cnn(5, 4'd9, 4'd9, 1'b0);
        accept(0, 4'd9, 1'b0);

        // Missing s_last.
        push_err_result();
        send_frame(NPIX, -1, 1'b0);
        check("missing_last", {res_valid, cnn_enable}, 2'b10);
        accept(0, 4'hF, 1'b1);

        // Watchdog expiry with cnn_done never asserted.
        send_frame(NPIX, NPIX - 1, 1'b0);
        exp_rises++;
        push_err_result();
        cnt = 0;
        while (cnn_enable && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        check("timeout_enable_cycles", cnt, 16);
        check("timeout_result", res_valid, 1);
        accept(0, 4'hF, 1'b1);

        // cnn_done on the watchdog expiry edge: done wins.
        send_frame(NPIX, NPIX - 1, 1'b0);
        exp_rises++;
        run_cnn(16, 4'd3, 4'd3, 1'b0);
        accept(0, 4'd3, 1'b0);

        // Out-of-range digit keeps the raw value but flags an error.
        send_frame(NPIX, NPIX - 1, 1'b0);
        exp_rises++;
        run_cnn(2, 4'd12, 4'd12, 1'b1);
        accept(1, 4'd12, 1'b1);

        // Reset at pixel 400, next frame restarts at (0,0).
        send_frame(400, -1, 1'b0);
        reset_pulse("reset_mid_frame");
        send_frame(NPIX, NPIX - 1, 1'b0);
        exp_rises++;
        run_cnn(4, 4'd1, 4'd1, 1'b0);
        accept(0, 4'd1, 1'b0);

        // Reset during RUN.
        send_frame(NPIX, NPIX - 1, 1'b0);
        exp_rises++;
        check("run_before_reset", cnn_enable, 1);
        repeat (3) @(negedge clk);
        reset_pulse("reset_mid_run");

        // Reset with a result pending.
        push_err_result();
        send_frame(4, 3, 1'b0);
        check("short_frame_result", res_valid, 1);
        reset_pulse("reset_mid_result");

        send_frame(NPIX, NPIX - 1, 1'b0);
        exp_rises++;
        run_cnn(6, 4'd0, 4'd0, 1'b0);
        accept(0, 4'd0, 1'b0);

        repeat (3) @(negedge clk);
        check("writes_outstanding", wr_q.size(), 0);
        check("results_outstanding", res_q.size(), 0);
        check("enable_rises", en_rises, exp_rises);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
